// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the EX-stage divider controller: state encodings,
// handshake constants and default widths.
package div_ctrl_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = 6;

    localparam logic DIV_START        = 1'b1;
    localparam logic DIV_STOP         = 1'b0;
    localparam logic RESULT_READY     = 1'b1;
    localparam logic RESULT_NOT_READY = 1'b0;

    typedef enum logic [1:0] {
        DIV_IDLE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

endpackage

// File: rtl/div_ctrl_if.sv
// Divider request/response bundle between the EX stage (master) and the
// divider controller (slave).
//   start       request, held until ready is seen
//   annul       pipeline flush, cancels the operation
//   signed_div  1 = DIV, 0 = DIVU
//   opdata1/2   dividend / divisor
//   result      {remainder, quotient}
//   ready       result valid
//   stallreq    stall request towards the pipeline controller
interface div_ctrl_if import div_ctrl_pkg::*; #(
    parameter int WIDTH = DIV_WIDTH
);
    logic                 start;
    logic                 annul;
    logic                 signed_div;
    logic [WIDTH-1:0]     opdata1;
    logic [WIDTH-1:0]     opdata2;
    logic [2*WIDTH-1:0]   result;
    logic                 ready;
    logic                 stallreq;

    modport master (
        output start, annul, signed_div, opdata1, opdata2,
        input  result, ready, stallreq
    );

    modport slave (
        input  start, annul, signed_div, opdata1, opdata2,
        output result, ready, stallreq
    );
endinterface

// File: rtl/div_ctrl_step.sv
// One restoring-division iteration, purely combinational.
//   work_i    {partial remainder, dividend bits / quotient bits so far}
//   divisor_i divisor magnitude
//   work_o    working register after shift, trial subtract and quotient bit
module div_step import div_ctrl_pkg::*; #(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [2*WIDTH-1:0] work_i,
    input  logic [WIDTH-1:0]   divisor_i,
    output logic [2*WIDTH-1:0] work_o
);

    logic [WIDTH:0]   top;
    logic             fits;
    logic [WIDTH-1:0] rem_next;

    always_comb begin
        // Upper WIDTH+1 bits of the register after a left shift by one.
        top  = work_i[2*WIDTH-1:WIDTH-1];
        fits = (top >= {1'b0, divisor_i});
        // The partial remainder is always below the divisor, so after a
        // successful subtract the result fits in WIDTH bits and the
        // modular low-half subtract is exact.
        rem_next = fits ? (top[WIDTH-1:0] - divisor_i) : top[WIDTH-1:0];
        work_o   = {rem_next, work_i[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle restoring divider controller for DIV/DIVU in the EX stage.
// Stalls the pipeline while busy and returns {remainder, quotient}.
//   clk  system clock, rising edge
//   rst  asynchronous reset, active low
//   bus  slave side of div_ctrl_if (request, operands, result, handshake)
//
// state      | meaning
// -----------+-----------------------------------------------------------
// DIV_IDLE   | waiting for start; operands sampled only here
// DIV_BYZERO | divisor was zero; one cycle then END with a zero result
// DIV_ON     | one restoring iteration per cycle, WIDTH iterations total
// DIV_END    | result valid; held until start drops or annul
module div_ctrl import div_ctrl_pkg::*; #(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic       clk,
    input  logic       rst,
    div_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    div_state_e           state_q,   state_d;
    logic [CNT_W-1:0]     cnt_q,     cnt_d;
    logic [2*WIDTH-1:0]   work_q,    work_d;
    logic [WIDTH-1:0]     divisor_q, divisor_d;
    logic                 op1_neg_q, op1_neg_d;
    logic                 op2_neg_q, op2_neg_d;
    logic                 signed_q,  signed_d;
    logic                 ready_q,   ready_d;
    logic [2*WIDTH-1:0]   result_q,  result_d;

    logic [2*WIDTH-1:0]   step_work;
    logic                 in_op1_neg;
    logic                 in_op2_neg;
    logic [WIDTH-1:0]     in_mag1;
    logic [WIDTH-1:0]     in_mag2;
    logic [WIDTH-1:0]     quot_raw;
    logic [WIDTH-1:0]     rem_raw;
    logic [WIDTH-1:0]     quot_fix;
    logic [WIDTH-1:0]     rem_fix;

    div_step #(.WIDTH(WIDTH)) u_step (
        .work_i    (work_q),
        .divisor_i (divisor_q),
        .work_o    (step_work)
    );

    // Operand magnitudes. The most negative value negates to itself, which
    // is the correct unsigned magnitude.
    always_comb begin
        in_op1_neg = bus.signed_div & bus.opdata1[WIDTH-1];
        in_op2_neg = bus.signed_div & bus.opdata2[WIDTH-1];
        in_mag1    = in_op1_neg ? -bus.opdata1 : bus.opdata1;
        in_mag2    = in_op2_neg ? -bus.opdata2 : bus.opdata2;
    end

    // Sign fix-up applied to the outcome of the final iteration.
    always_comb begin
        quot_raw = step_work[WIDTH-1:0];
        rem_raw  = step_work[2*WIDTH-1:WIDTH];
        quot_fix = (signed_q & (op1_neg_q ^ op2_neg_q)) ? -quot_raw : quot_raw;
        rem_fix  = (signed_q & op1_neg_q) ? -rem_raw : rem_raw;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        divisor_d = divisor_q;
        op1_neg_d = op1_neg_q;
        op2_neg_d = op2_neg_q;
        signed_d  = signed_q;
        ready_d   = ready_q;
        result_d  = result_q;

        case (state_q)
            DIV_IDLE: begin
                ready_d  = RESULT_NOT_READY;
                result_d = '0;
                if (bus.start == DIV_START && !bus.annul) begin
                    if (bus.opdata2 == '0) begin
                        state_d = DIV_BYZERO;
                    end else begin
                        state_d   = DIV_ON;
                        cnt_d     = '0;
                        work_d    = {{WIDTH{1'b0}}, in_mag1};
                        divisor_d = in_mag2;
                        op1_neg_d = in_op1_neg;
                        op2_neg_d = in_op2_neg;
                        signed_d  = bus.signed_div;
                    end
                end
            end

            DIV_BYZERO: begin
                if (bus.annul) begin
                    state_d = DIV_IDLE;
                end else begin
                    state_d  = DIV_END;
                    ready_d  = RESULT_READY;
                    result_d = '0;
                end
            end

            DIV_ON: begin
                if (bus.annul) begin
                    state_d  = DIV_IDLE;
                    ready_d  = RESULT_NOT_READY;
                    result_d = '0;
                end else begin
                    work_d = step_work;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d  = DIV_END;
                        ready_d  = RESULT_READY;
                        result_d = {rem_fix, quot_fix};
                    end
                end
            end

            DIV_END: begin
                if (bus.annul || bus.start == DIV_STOP) begin
                    state_d  = DIV_IDLE;
                    ready_d  = RESULT_NOT_READY;
                    result_d = '0;
                end
            end

            default: begin
                state_d  = DIV_IDLE;
                ready_d  = RESULT_NOT_READY;
                result_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= '0;
            work_q    <= '0;
            divisor_q <= '0;
            op1_neg_q <= 1'b0;
            op2_neg_q <= 1'b0;
            signed_q  <= 1'b0;
            ready_q   <= RESULT_NOT_READY;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            divisor_q <= divisor_d;
            op1_neg_q <= op1_neg_d;
            op2_neg_q <= op2_neg_d;
            signed_q  <= signed_d;
            ready_q   <= ready_d;
            result_q  <= result_d;
        end
    end

    assign bus.result   = result_q;
    assign bus.ready    = ready_q;
    // Combinational so the stall covers the very cycle start first appears.
    assign bus.stallreq = bus.start & ~ready_q & ~bus.annul;

endmodule

// File: tb/tb_div_ctrl.sv
module tb_div_ctrl;
    import div_ctrl_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    div_ctrl_if #(.WIDTH(W)) dif ();

    div_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif.slave)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [2*W-1:0] exp_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain 64-bit integer division (truncating, remainder takes
    // the dividend's sign), zero result for a zero divisor.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic sgn);
        longint sa, sb, q, r;
        logic [63:0] qv, rv;
        if (b == 32'h0) return 64'h0;
        sa = sgn ? longint'($signed(a)) : longint'({32'h0, a});
        sb = sgn ? longint'($signed(b)) : longint'({32'h0, b});
        q  = sa / sb;
        r  = sa % sb;
        qv = q;
        rv = r;
        return {rv[31:0], qv[31:0]};
    endfunction

    // Monitor: every rising ready must match the oldest outstanding request.
    logic ready_prev = 1'b0;
    always @(negedge clk) begin
        if (dif.ready && !ready_prev) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_ready: result 0x%0h appeared with no request outstanding",
                         dif.result);
            end else begin
                chk("result", dif.result, exp_q.pop_front());
            end
        end
        ready_prev = dif.ready;
    end

    // Issue one divide, check latency and stall, hold, then release or reset.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                          input logic [63:0] exp, input int hold, input bit reset_in_end);
        int lat_exp;
        int edges;
        int stall_n;
        bit seen;
        lat_exp = (b == 32'h0) ? 2 : 33;
        edges   = 0;
        stall_n = 0;
        seen    = 1'b0;
        @(negedge clk);
        dif.start      = 1'b1;
        dif.annul      = 1'b0;
        dif.signed_div = sgn;
        dif.opdata1    = a;
        dif.opdata2    = b;
        exp_q.push_back(exp);
        for (int i = 0; i < 100; i++) begin
            #1;
            if (dif.ready) begin
                seen = 1'b1;
                break;
            end
            if (dif.stallreq) stall_n++;
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (edges == 1) begin
                // Operands must be ignored once the operation is under way.
                dif.opdata1    = $urandom;
                dif.opdata2    = $urandom;
                dif.signed_div = ~sgn;
            end
        end
        chk("ready_seen", 64'(seen), 64'd1);
        chk("latency", 64'(edges), 64'(lat_exp));
        chk("stall_cycles", 64'(stall_n), 64'(lat_exp));
        chk("stall_low_at_ready", 64'(dif.stallreq), 64'd0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            #1;
            chk("hold_ready", 64'(dif.ready), 64'd1);
            chk("hold_result", dif.result, exp);
        end
        if (reset_in_end) begin
            #2;
            rst = 1'b0;
            #1;
            chk("rst_end_ready", 64'(dif.ready), 64'd0);
            chk("rst_end_result", dif.result, 64'd0);
            dif.start = 1'b0;
            @(negedge clk);
            rst = 1'b1;
        end else begin
            dif.start = 1'b0;
            @(negedge clk);
            #1;
            chk("drop_ready", 64'(dif.ready), 64'd0);
            chk("drop_result", dif.result, 64'd0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, b;
        logic        sgn;
        int          ready_hits;

        rst            = 1'b0;
        dif.start      = 1'b0;
        dif.annul      = 1'b0;
        dif.signed_div = 1'b0;
        dif.opdata1    = '0;
        dif.opdata2    = '0;
        repeat (3) @(negedge clk);
        chk("reset_ready", 64'(dif.ready), 64'd0);
        chk("reset_result", dif.result, 64'd0);
        chk("reset_stall", 64'(dif.stallreq), 64'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Directed cases
        run_op(32'd100, 32'd7, 1'b0, {32'h00000002, 32'h0000000E}, 0, 1'b0);
        run_op(32'hFFFFFFF9, 32'h2, 1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, 1, 1'b0);
        run_op(32'h7, 32'hFFFFFFFE, 1'b1, {32'h00000001, 32'hFFFFFFFD}, 0, 1'b0);
        run_op(32'h12345678, 32'h0, 1'b0, 64'h0, 0, 1'b0);
        run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, {32'h00000000, 32'h80000000}, 0, 1'b0);
        run_op(32'hDEADBEEF, 32'h00001234, 1'b0, ref_div(32'hDEADBEEF, 32'h1234, 1'b0), 5, 1'b0);

        // Start with annul in the same cycle: must stay idle
        @(negedge clk);
        dif.start = 1'b1;
        dif.annul = 1'b1;
        dif.opdata1 = 32'd50;
        dif.opdata2 = 32'd5;
        #1;
        chk("start_annul_stall", 64'(dif.stallreq), 64'd0);
        @(negedge clk);
        dif.start = 1'b0;
        dif.annul = 1'b0;

        // Annul in the middle of an operation
        @(negedge clk);
        dif.start      = 1'b1;
        dif.signed_div = 1'b0;
        dif.opdata1    = 32'd1000000;
        dif.opdata2    = 32'd3;
        repeat (11) @(negedge clk);
        dif.annul = 1'b1;
        #1;
        chk("annul_stall_low", 64'(dif.stallreq), 64'd0);
        @(negedge clk);
        #1;
        chk("annul_ready", 64'(dif.ready), 64'd0);
        dif.annul = 1'b0;
        dif.start = 1'b0;
        ready_hits = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dif.ready) ready_hits++;
        end
        chk("annul_no_ready", 64'(ready_hits), 64'd0);
        run_op(32'd9, 32'd3, 1'b0, {32'h0, 32'h3}, 0, 1'b0);

        // Asynchronous reset mid-operation
        @(negedge clk);
        dif.start      = 1'b1;
        dif.signed_div = 1'b1;
        dif.opdata1    = 32'hFFFFFF00;
        dif.opdata2    = 32'd7;
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_on_ready", 64'(dif.ready), 64'd0);
        chk("rst_on_result", dif.result, 64'd0);
        dif.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run_op(32'd1000, 32'd33, 1'b0, {32'd10, 32'd30}, 0, 1'b0);

        // Asynchronous reset while the result is presented
        run_op(32'hFFFF0000, 32'd3, 1'b1, ref_div(32'hFFFF0000, 32'd3, 1'b1), 2, 1'b1);
        repeat (2) @(negedge clk);

        // Randomised operations
        for (int n = 0; n < 25; n++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'h80000000;
            case ($urandom_range(0, 5))
                0:       b = 32'h0;
                1:       b = $urandom_range(1, 15);
                2:       b = -32'($urandom_range(1, 15));
                3:       b = 32'hFFFFFFFF;
                default: b = $urandom;
            endcase
            run_op(a, b, sgn, ref_div(a, b, sgn), $urandom_range(0, 3), 1'b0);
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
